sprite_fetch_engine: RTL and testbench

Parametrised pixel-to-memory-address engine for the FGA video pipeline, sitting between the VGA timing generator, the sprite register bank and the colour memory. For each active-area pixel it scans NUM_SPRITES sprite slots in priority order and emits either the colour-memory address of the covering sprite texel or the background address. It generalises the single-slot print path to N sprites, configurable screen and sprite sizes, and a valid/ready output handshake with backpressure.

---
 rtl/print_pkg.sv | 33 +++
 rtl/sprite_hit_check.sv | 52 +++++
 rtl/sprite_fetch_engine.sv | 94 +++++++++
 tb/tb_sprite_fetch_engine.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/print_pkg.sv
// print_pkg: shared FSM states, slot-word layout helpers and default screen/sprite constants.
package print_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_SPRITE_SIZE = 20;

    // Slot word is {enable, mirror, x, y, offset}, offset in the LSBs.
    localparam int OFS_LSB = 0;

    function automatic int slot_w(int cw, int ow);
        return 2 + 2 * cw + ow;
    endfunction

    function automatic int y_lsb(int ow);
        return ow;
    endfunction

    function automatic int x_lsb(int cw, int ow);
        return ow + cw;
    endfunction

    function automatic int mirror_bit(int cw, int ow);
        return ow + 2 * cw;
    endfunction

    function automatic int enable_bit(int cw, int ow);
        return ow + 2 * cw + 1;
    endfunction

endpackage

// File: rtl/sprite_hit_check.sv
// sprite_hit_check: combinational coverage test and texel address for one sprite slot word.
// SPRITE_MIRROR_EN enables horizontal mirroring from the slot's mirror bit.
module sprite_hit_check
    import print_pkg::*;
#(
    parameter int COORD_W     = 10,
    parameter int ADDR_W      = 17,
    parameter int OFS_W       = 8,
    parameter int SPRITE_SIZE = DEF_SPRITE_SIZE,
    localparam int SLOT_W     = slot_w(COORD_W, OFS_W)
) (
    input  logic [SLOT_W-1:0]  slot,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic               hit,
    output logic [ADDR_W-1:0]  addr
);

    localparam int EN_B = enable_bit(COORD_W, OFS_W);
    localparam int MR_B = mirror_bit(COORD_W, OFS_W);
    localparam int X_L  = x_lsb(COORD_W, OFS_W);
    localparam int Y_L  = y_lsb(OFS_W);

    logic [COORD_W-1:0] sx, sy, dx_raw, dx, dy;
    logic [OFS_W-1:0]   ofs;
    logic [COORD_W:0]   size_w;

    assign sx     = slot[X_L +: COORD_W];
    assign sy     = slot[Y_L +: COORD_W];
    assign ofs    = slot[OFS_LSB +: OFS_W];
    assign size_w = (COORD_W+1)'(SPRITE_SIZE);

    // One extra bit so sx+SPRITE_SIZE cannot wrap near the coordinate limit.
    assign hit = slot[EN_B]
              && ({1'b0, px} >= {1'b0, sx}) && ({1'b0, px} < {1'b0, sx} + size_w)
              && ({1'b0, py} >= {1'b0, sy}) && ({1'b0, py} < {1'b0, sy} + size_w);

    assign dx_raw = px - sx;
    assign dy     = py - sy;

`ifdef SPRITE_MIRROR_EN
    assign dx = slot[MR_B] ? COORD_W'(SPRITE_SIZE - 1) - dx_raw : dx_raw;
`else
    logic unused_mirror;
    assign unused_mirror = slot[MR_B];
    assign dx = dx_raw;
`endif

    assign addr = ADDR_W'(ofs) * ADDR_W'(SPRITE_SIZE * SPRITE_SIZE)
                + ADDR_W'(dy) * ADDR_W'(SPRITE_SIZE) + ADDR_W'(dx);

endmodule

// File: rtl/sprite_fetch_engine.sv
// sprite_fetch_engine: per-pixel priority scan of sprite slots producing a colour-memory address.
// SPRITE_MIRROR_EN enables sprite mirroring (handled in sprite_hit_check).
module sprite_fetch_engine
    import print_pkg::*;
#(
    parameter int COORD_W     = 10,
    parameter int ADDR_W      = 17,
    parameter int NUM_SPRITES = 8,
    parameter int SPRITE_SIZE = DEF_SPRITE_SIZE,
    parameter int OFS_W       = 8,
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int BG_ADDR     = 0,
    localparam int IDX_W      = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1,
    localparam int SLOT_W     = slot_w(COORD_W, OFS_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixel_valid,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    output logic               pix_ready,
    output logic [IDX_W-1:0]   reg_index,
    input  logic [SLOT_W-1:0]  reg_data,
    output logic               addr_valid,
    input  logic               addr_ready,
    output logic [ADDR_W-1:0]  addr,
    output logic               is_sprite,
    output logic [IDX_W-1:0]   sprite_id,
    output logic               printing_screen
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SPRITES - 1);

    state_t             state;
    logic [IDX_W-1:0]   cnt, cmp_idx;
    logic               cmp_valid, in_screen, hit;
    logic [COORD_W-1:0] px, py;
    logic [ADDR_W-1:0]  hit_addr;

    assign in_screen  = ({1'b0, pixel_x} < (COORD_W+1)'(SCREEN_W))
                     && ({1'b0, pixel_y} < (COORD_W+1)'(SCREEN_H));
    assign pix_ready  = state == IDLE;
    assign addr_valid = state == OUT;
    assign reg_index  = cnt;

    sprite_hit_check #(
        .COORD_W(COORD_W), .ADDR_W(ADDR_W), .OFS_W(OFS_W), .SPRITE_SIZE(SPRITE_SIZE)
    ) u_hit (
        .slot(reg_data), .px(px), .py(py), .hit(hit), .addr(hit_addr)
    );

    // reg_data lags reg_index by one cycle, so cmp_idx names the slot being compared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            cmp_idx         <= '0;
            cmp_valid       <= 1'b0;
            px              <= '0;
            py              <= '0;
            addr            <= '0;
            is_sprite       <= 1'b0;
            sprite_id       <= '0;
            printing_screen <= 1'b0;
        end else begin
            printing_screen <= pixel_valid && in_screen;
            case (state)
                IDLE: if (pixel_valid) begin
                    px        <= pixel_x;
                    py        <= pixel_y;
                    cnt       <= '0;
                    cmp_valid <= 1'b0;
                    state     <= in_screen ? SCAN : IDLE;
                end
                SCAN: begin
                    cnt       <= cnt == LAST ? cnt : cnt + 1'b1;
                    cmp_idx   <= cnt;
                    cmp_valid <= 1'b1;
                    if (cmp_valid && (hit || cmp_idx == LAST)) begin
                        state     <= OUT;
                        addr      <= hit ? hit_addr : ADDR_W'(BG_ADDR);
                        is_sprite <= hit;
                        sprite_id <= hit ? cmp_idx : '0;
                        cnt       <= '0;
                    end
                end
                OUT: if (addr_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_fetch_engine.sv
// tb_sprite_fetch_engine: directed and randomized pixels checked against a slot-table reference model.
module tb_sprite_fetch_engine;

    localparam int N  = 8;
    localparam int SZ = 20;
    localparam int AW = 17;
    localparam int BG = 0;

    logic        clk = 1'b0;
    logic        reset, pixel_valid, addr_ready;
    logic [9:0]  pixel_x, pixel_y;
    logic        pix_ready, addr_valid, is_sprite, printing_screen;
    logic [2:0]  reg_index, sprite_id;
    logic [29:0] reg_data;
    logic [16:0] addr;

    logic       t_en[N], t_mir[N];
    logic [9:0] t_x[N], t_y[N];
    logic [7:0] t_ofs[N];

    int checks = 0;
    int failures = 0;

    sprite_fetch_engine dut (
        .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pix_ready(pix_ready), .reg_index(reg_index), .reg_data(reg_data), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .addr(addr), .is_sprite(is_sprite), .sprite_id(sprite_id),
        .printing_screen(printing_screen)
    );

    always #5 clk = ~clk;

    // Register bank with one cycle read latency.
    always @(posedge clk)
        reg_data <= {t_en[reg_index], t_mir[reg_index], t_x[reg_index], t_y[reg_index], t_ofs[reg_index]};

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(int x, int y, output int a, output int sp, output int id, output int lat);
        a = BG; sp = 0; id = 0; lat = N + 1;
        for (int k = 0; k < N; k++) begin
            int sx, sy, dx;
            sx = int'(t_x[k]);
            sy = int'(t_y[k]);
            if (t_en[k] && x >= sx && x < sx + SZ && y >= sy && y < sy + SZ) begin
                dx = x - sx;
`ifdef SPRITE_MIRROR_EN
                if (t_mir[k]) dx = SZ - 1 - dx;
`endif
                a   = (int'(t_ofs[k]) * SZ * SZ + (y - sy) * SZ + dx) % (1 << AW);
                sp  = 1;
                id  = k;
                lat = k + 2;
                return;
            end
        end
    endfunction

    task automatic clear_table();
        for (int k = 0; k < N; k++) begin
            t_en[k] = 0; t_mir[k] = 0; t_x[k] = 0; t_y[k] = 0; t_ofs[k] = 0;
        end
    endtask

    task automatic set_slot(int k, int en, int mir, int x, int y, int ofs);
        t_en[k] = 1'(en); t_mir[k] = 1'(mir); t_x[k] = 10'(x); t_y[k] = 10'(y); t_ofs[k] = 8'(ofs);
    endtask

    task automatic run_pixel(int x, int y, int hold);
        int ea, es, ei, el, n, ins;
        logic [16:0] held;
        ins = (x < 640 && y < 480) ? 1 : 0;
        check("pix_ready_idle", pix_ready, 1);
        pixel_valid = 1; pixel_x = 10'(x); pixel_y = 10'(y);
        @(posedge clk); #1;
        pixel_valid = 0;
        check("printing_screen", printing_screen, ins);
        if (ins == 0) begin
            repeat (3) begin @(posedge clk); #1; end
            check("dropped_addr_valid", addr_valid, 0);
            check("dropped_pix_ready", pix_ready, 1);
            return;
        end
        model(x, y, ea, es, ei, el);
        n = 0;
        while (!addr_valid && n < 60) begin @(posedge clk); #1; n++; end
        check("latency", n, el);
        check("addr", addr, ea);
        check("is_sprite", is_sprite, es);
        check("sprite_id", sprite_id, ei);
        held = addr;
        for (int i = 0; i < hold; i++) begin
            pixel_valid = 1;
            pixel_x = 10'($urandom_range(0, 300));
            pixel_y = 10'($urandom_range(0, 300));
            @(posedge clk); #1;
            check("hold_addr", addr, held);
            check("hold_addr_valid", addr_valid, 1);
            check("hold_pix_ready", pix_ready, 0);
        end
        pixel_valid = 0;
        addr_ready = 1;
        @(posedge clk); #1;
        addr_ready = 0;
        check("release_addr_valid", addr_valid, 0);
    endtask

    initial begin
        reset = 1; pixel_valid = 0; addr_ready = 0; pixel_x = 0; pixel_y = 0;
        clear_table();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_ready", pix_ready, 1);
        check("rst_addr_valid", addr_valid, 0);
        check("rst_addr", addr, 0);
        check("rst_reg_index", reg_index, 0);
        check("rst_printing", printing_screen, 0);
        reset = 0;
        @(posedge clk); #1;

        set_slot(0, 1, 0, 100, 50, 2);
        run_pixel(105, 52, 0);
        check("model_845", addr, 845);

        clear_table();
        run_pixel(10, 10, 0);

        set_slot(3, 1, 0, 190, 195, 7);
        set_slot(5, 1, 0, 195, 190, 9);
        run_pixel(200, 200, 0);

        clear_table();
        set_slot(0, 1, 0, 100, 50, 1);
        run_pixel(119, 52, 0);
        run_pixel(120, 52, 0);
        run_pixel(640, 0, 0);

        clear_table();
        set_slot(0, 1, 1, 100, 50, 0);
        run_pixel(105, 50, 0);
`ifdef SPRITE_MIRROR_EN
        check("mirror_addr", addr, 14);
`else
        check("mirror_addr", addr, 5);
`endif

        set_slot(2, 1, 0, 300, 300, 3);
        run_pixel(310, 305, 4);

        clear_table();
        pixel_valid = 1; pixel_x = 10; pixel_y = 10;
        @(posedge clk); #1;
        pixel_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1;
        #1;
        check("midscan_pix_ready", pix_ready, 1);
        check("midscan_addr_valid", addr_valid, 0);
        check("midscan_reg_index", reg_index, 0);
        check("midscan_addr", addr, 0);
        check("midscan_is_sprite", is_sprite, 0);
        check("midscan_sprite_id", sprite_id, 0);
        check("midscan_printing", printing_screen, 0);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;

        for (int t = 0; t < 60; t++) begin
            if (t % 6 == 0)
                for (int k = 0; k < N; k++)
                    set_slot(k, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                             int'($urandom_range(0, 120)), int'($urandom_range(0, 120)),
                             int'($urandom_range(0, 255)));
            if ($urandom_range(0, 9) == 0)
                run_pixel(int'($urandom_range(640, 1023)), int'($urandom_range(0, 1023)), 0);
            else
                run_pixel(int'($urandom_range(0, 140)), int'($urandom_range(0, 140)),
                          int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
